// File: rtl/reg_file_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_reader_if
// Purpose  : Write-port and dual read-port bundle for the register file.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_file_reader_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              ra_en;
  logic [ADDR_W-1:0] ra_addr;
  logic              rb_en;
  logic [ADDR_W-1:0] rb_addr;
  logic [WIDTH-1:0]  ra_data;
  logic              ra_valid;
  logic [WIDTH-1:0]  rb_data;
  logic              rb_valid;

  modport master (
    output wr_en, wr_addr, wr_data, ra_en, ra_addr, rb_en, rb_addr,
    input  ra_data, ra_valid, rb_data, rb_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, ra_en, ra_addr, rb_en, rb_addr,
    output ra_data, ra_valid, rb_data, rb_valid
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_reader.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_reader
// Purpose  : Register file with one write port and two registered read ports
//            (1-cycle latency, same-edge write-to-read bypass).
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_reader #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  reg_file_reader_if.slave    bus
);

  localparam int c_DEPTH = 2 ** ADDR_W;
  localparam bit c_ZERO  = (ZERO_REG != 0);

  logic [WIDTH-1:0] r_mem [0:c_DEPTH-1];
  logic [WIDTH-1:0] r_ra_data;
  logic [WIDTH-1:0] r_rb_data;
  logic             r_ra_valid;
  logic             r_rb_valid;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  assign w_wr_ok = bus.wr_en && !(c_ZERO && (bus.wr_addr == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Zero register outranks the bypass so a write to entry 0 never leaks out.
  always_comb begin
    w_sel_a = r_mem[bus.ra_addr];
    if (c_ZERO && (bus.ra_addr == '0)) begin
      w_sel_a = '0;
    end else if (bus.wr_en && (bus.wr_addr == bus.ra_addr)) begin
      w_sel_a = bus.wr_data;
    end
  end

  always_comb begin
    w_sel_b = r_mem[bus.rb_addr];
    if (c_ZERO && (bus.rb_addr == '0)) begin
      w_sel_b = '0;
    end else if (bus.wr_en && (bus.wr_addr == bus.rb_addr)) begin
      w_sel_b = bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ra_data  <= '0;
      r_ra_valid <= 1'b0;
    end else begin
      r_ra_valid <= bus.ra_en;
      if (bus.ra_en) begin
        r_ra_data <= w_sel_a;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= bus.rb_en;
      if (bus.rb_en) begin
        r_rb_data <= w_sel_b;
      end
    end
  end

  assign bus.ra_data  = r_ra_data;
  assign bus.ra_valid = r_ra_valid;
  assign bus.rb_data  = r_rb_data;
  assign bus.rb_valid = r_rb_valid;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_reader
// Purpose  : Scoreboard bench for reg_file_reader (ZERO_REG=1 and ZERO_REG=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        ra_en = 1'b0;
  logic [4:0]  ra_addr = '0;
  logic        rb_en = 1'b0;
  logic [4:0]  rb_addr = '0;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model [32];
  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];

  always #5 clk = ~clk;

  reg_file_reader_if #(.WIDTH(32), .ADDR_W(5)) bus0 ();
  reg_file_reader_if #(.WIDTH(32), .ADDR_W(5)) bus1 ();

  assign bus0.wr_en   = wr_en;   assign bus1.wr_en   = wr_en;
  assign bus0.wr_addr = wr_addr; assign bus1.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data; assign bus1.wr_data = wr_data;
  assign bus0.ra_en   = ra_en;   assign bus1.ra_en   = ra_en;
  assign bus0.ra_addr = ra_addr; assign bus1.ra_addr = ra_addr;
  assign bus0.rb_en   = rb_en;   assign bus1.rb_en   = rb_en;
  assign bus0.rb_addr = rb_addr; assign bus1.rb_addr = rb_addr;

  reg_file_reader #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  reg_file_reader #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // Expected read value for the ZERO_REG=1 instance given the inputs now driven.
  function automatic logic [31:0] expect_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wr_en && (wr_addr == a)) return wr_data;
    return model[a];
  endfunction

  task automatic clear_model();
    foreach (model[i]) model[i] = 32'h0;
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ae, input logic [4:0] aa,
                       input logic be, input logic [4:0] ba);
    wr_en = we; wr_addr = wa; wr_data = wd;
    ra_en = ae; ra_addr = aa; rb_en = be; rb_addr = ba;
    if (ae) exp_a.push_back(expect_read(aa));
    if (be) exp_b.push_back(expect_read(ba));
    if (we && (wa != 5'd0)) model[wa] = wd;
    @(posedge clk);
    #1;
    wr_en = 1'b0; ra_en = 1'b0; rb_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    reset = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus0.ra_data, bus0.rb_data} !== 64'h0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {bus0.ra_data, bus0.rb_data});
    end
    n_cmp++;
    if ({bus0.ra_valid, bus0.rb_valid} !== 2'b00) begin
      n_err++; $display("FAIL reset_valid: got %b want 00", {bus0.ra_valid, bus0.rb_valid});
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    e = (exp_a.size() != 0) ? exp_a.pop_front() : 'x;
    n_cmp++;
    if (bus0.ra_data !== e || bus0.ra_valid !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_read: got %h/%b want %h/1", bus0.ra_data, bus0.ra_valid, e);
    end
    // Assert reset between edges: outputs must clear without a clock.
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus0.ra_data, bus0.rb_data, bus0.ra_valid, bus0.rb_valid} !== 66'h0) begin
      n_err++; $display("FAIL async_reset: got %h/%h/%b%b want 0", bus0.ra_data, bus0.rb_data,
                        bus0.ra_valid, bus0.rb_valid);
    end
    clear_model();
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus0.ra_valid, bus0.rb_valid, bus0.ra_data} !== 34'h0) begin
      n_err++; $display("FAIL reset_hold: got %b%b/%h want 0", bus0.ra_valid, bus0.rb_valid, bus0.ra_data);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    n_cmp++;
    if ({bus0.ra_valid, bus0.rb_valid} !== 2'b00) begin
      n_err++; $display("FAIL release_no_valid: got %b%b want 00", bus0.ra_valid, bus0.rb_valid);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
    e = (exp_a.size() != 0) ? exp_a.pop_front() : 'x;
    n_cmp++;
    if (bus0.ra_data !== e || e !== 32'h0) begin
      n_err++; $display("FAIL post_reset_r5: got %h want %h", bus0.ra_data, e);
    end
  endtask

  task automatic test_basic();
    logic [31:0] e;
    drive(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);
    e = (exp_a.size() != 0) ? exp_a.pop_front() : 'x;
    n_cmp++;
    if (bus0.ra_data !== e || bus0.ra_valid !== 1'b1) begin
      n_err++; $display("FAIL basic_read: got %h/%b want %h/1", bus0.ra_data, bus0.ra_valid, e);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    n_cmp++;
    if (bus0.ra_valid !== 1'b0 || bus0.ra_data !== 32'h12345678) begin
      n_err++; $display("FAIL basic_hold: got %h/%b want 12345678/0", bus0.ra_data, bus0.ra_valid);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] ea, eb;
    drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 1'b1, 5'd7);
    ea = (exp_a.size() != 0) ? exp_a.pop_front() : 'x;
    eb = (exp_b.size() != 0) ? exp_b.pop_front() : 'x;
    n_cmp++;
    if (bus0.ra_data !== ea || bus0.ra_valid !== 1'b1) begin
      n_err++; $display("FAIL bypass_a: got %h/%b want %h/1", bus0.ra_data, bus0.ra_valid, ea);
    end
    n_cmp++;
    if (bus0.rb_data !== eb || bus0.rb_valid !== 1'b1) begin
      n_err++; $display("FAIL bypass_b: got %h/%b want %h/1", bus0.rb_data, bus0.rb_valid, eb);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0);
    ea = (exp_a.size() != 0) ? exp_a.pop_front() : 'x;
    n_cmp++;
    if (bus0.ra_data !== ea) begin
      n_err++; $display("FAIL bypass_later: got %h want %h", bus0.ra_data, ea);
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] ea, eb;
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd0);
    for (int k = 0; k < 2; k++) begin
      // k=0 reads the stored entry, k=1 hits the same-edge bypass path
      drive(k == 1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
      ea = (exp_a.size() != 0) ? exp_a.pop_front() : 'x;
      eb = (exp_b.size() != 0) ? exp_b.pop_front() : 'x;
      n_cmp++;
      if (bus0.ra_data !== ea || bus0.rb_data !== eb || ea !== 32'h0) begin
        n_err++; $display("FAIL zero_reg_%0d: got %h/%h want %h/%h", k, bus0.ra_data, bus0.rb_data, ea, eb);
      end
      n_cmp++;
      if (bus1.ra_data !== 32'hFFFFFFFF || bus1.rb_data !== 32'hFFFFFFFF) begin
        n_err++; $display("FAIL no_zero_reg_%0d: got %h/%h want ffffffff", k, bus1.ra_data, bus1.rb_data);
      end
    end
  endtask

  task automatic test_independent();
    logic [31:0] ea, eb;
    drive(1'b1, 5'd1, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b1, 5'd31, 32'h1F1F1F1F, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd31);
    ea = (exp_a.size() != 0) ? exp_a.pop_front() : 'x;
    eb = (exp_b.size() != 0) ? exp_b.pop_front() : 'x;
    n_cmp++;
    if (bus0.ra_data !== ea || bus0.rb_data !== eb) begin
      n_err++; $display("FAIL indep_read: got %h/%h want %h/%h", bus0.ra_data, bus0.rb_data, ea, eb);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0, 5'd0);
    ea = (exp_a.size() != 0) ? exp_a.pop_front() : 'x;
    n_cmp++;
    if (bus0.rb_valid !== 1'b0 || bus0.rb_data !== 32'h1F1F1F1F || bus0.ra_data !== ea) begin
      n_err++; $display("FAIL indep_hold: got b=%h/%b a=%h want b=1f1f1f1f/0 a=%h",
                        bus0.rb_data, bus0.rb_valid, bus0.ra_data, ea);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] ea, eb;
    int          nva = 0;
    int          nvb = 0;
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 1'b0, 5'd0, 1'b0, 5'd0);
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
      nva += int'(bus0.ra_valid);
      nvb += int'(bus0.rb_valid);
      ea = (exp_a.size() != 0) ? exp_a.pop_front() : 'x;
      eb = (exp_b.size() != 0) ? exp_b.pop_front() : 'x;
      n_cmp++;
      if (bus0.ra_data !== ea) begin
        n_err++; $display("FAIL sweep_a[%0d]: got %h want %h", i, bus0.ra_data, ea);
      end
      n_cmp++;
      if (bus0.rb_data !== eb) begin
        n_err++; $display("FAIL sweep_b[%0d]: got %h want %h", 31 - i, bus0.rb_data, eb);
      end
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    n_cmp++;
    if (nva != 32 || nvb != 32 || {bus0.ra_valid, bus0.rb_valid} !== 2'b00) begin
      n_err++; $display("FAIL sweep_valids: got %0d/%0d trailing %b%b want 32/32 00",
                        nva, nvb, bus0.ra_valid, bus0.rb_valid);
    end
    n_cmp++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_err++; $display("FAIL sweep_leftover: got %0d/%0d want 0/0", exp_a.size(), exp_b.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_zero_reg();
    test_independent();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_reader.md
Name: reg_file_reader

Overview:
- Multi-entry general-purpose register file for the Processor, built on the same storage semantics as the single enabled 32-bit register: asynchronous clear, write on clock edge when enabled.
- Adds two independent registered read ports: the read (consumer) side of the register storage.
- Sits between instruction decode (read addresses) and write-back (write port).
- Feeds operands to the ALU stage with a one-cycle read latency and a write-to-read bypass.

Parameters:
- WIDTH, 32, data width of each entry and of all data ports.
- ADDR_W, 5, address width; depth = 2**ADDR_W entries.
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero: writes ignored, reads return 0.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- wr_en  input  1  write enable, sampled at posedge clk.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  WIDTH  write data.
- ra_en  input  1  port A read request, sampled at posedge clk.
- ra_addr  input  ADDR_W  port A read address.
- rb_en  input  1  port B read request.
- rb_addr  input  ADDR_W  port B read address.
- ra_data  output  WIDTH  port A registered read data.
- ra_valid  output  1  port A data valid, high for the cycle after an accepted request.
- rb_data  output  WIDTH  port B registered read data.
- rb_valid  output  1  port B data valid.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - all entries cleared to 0.
  - ra_data=rb_data=0; ra_valid=rb_valid=0.
  - Held while reset=0.
  - Deassertion takes effect at the first posedge with reset=1.
- Write:
  - at posedge, if wr_en=1, entry[wr_addr] <= wr_data.
  - If ZERO_REG=1 and wr_addr=0, the write is discarded.
  - wr_en=0 leaves all entries unchanged.
- Read, port A (port B identical, independent):
  - at posedge, if ra_en=1, ra_data <= selected value; ra_valid <= 1.
  - Latency is 1 cycle: address at edge N, data and valid visible after edge N until the next update.
  - if ra_en=0: ra_data holds its previous value; ra_valid <= 0.
- Selected value, in priority order:
  - (1) ZERO_REG=1 and addr=0 -> 0.
  - (2) wr_en=1 and wr_addr=addr -> wr_data, same-edge bypass (write-before-read).
  - (3) otherwise entry[addr].
- Both ports may read the same address in the same cycle; both return the identical value.
- Reset mid-operation: a read or write in flight at reset assertion is lost. Outputs clear immediately; no valid pulse follows reset release.
- No state machine beyond the per-port valid flag; there is no back-pressure, and every accepted request produces exactly one valid cycle.
- Addresses are full range 0..2**ADDR_W-1, with no out-of-range case.

Test Plan:
- Reset clears state:
  - Stimulus: write 0xDEADBEEF to r5; assert reset=0 between clock edges.
  - Required: ra_data/rb_data drop to 0 and valids drop to 0 without waiting for a clock edge.
  - Then read r5 after release -> 0x00000000.
- Basic write/read:
  - Stimulus: write 0x12345678 to r3, then next cycle ra_en=1, ra_addr=3.
  - Required: ra_data=0x12345678 and ra_valid=1 after that edge; ra_valid=0 the following cycle with ra_en=0, and ra_data held.
- Bypass:
  - Stimulus: same edge wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, ra_en=1, ra_addr=7, and rb_en=1, rb_addr=7.
  - Required: both ports return 0xA5A5A5A5 with valid=1.
  - A later read of r7 also returns 0xA5A5A5A5.
- Zero register:
  - Stimulus: write 0xFFFFFFFF to r0; read r0 on both ports, including the same-edge bypass case.
  - Required: always 0x00000000.
  - With ZERO_REG=0, the same sequence returns 0xFFFFFFFF.
- Independent ports:
  - Stimulus: r1=0x11111111, r31=0x1F1F1F1F; same cycle ra_addr=1, rb_addr=31, both enabled.
  - Required: ra_data=0x11111111, rb_data=0x1F1F1F1F.
  - rb_en=0 next cycle: rb_valid=0, rb_data holds 0x1F1F1F1F.
- Full sweep:
  - Stimulus: write addr*0x01010101 to every address 1..31, then read all addresses back on port A and in reverse order on port B.
  - Required: every value matches, one valid per request, no stale data.
